riscv_cpu_top: RTL and testbench
================================

RISCV_CPU_TOP -- requirements
Module: riscv_cpu_top

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: imem_addr  output  32  byte address of the current instruction; equals PC.
REQ-005 Port: imem_data_in  input  32  instruction word, combinational from imem_addr, same cycle.
REQ-006 Port: dmem_addr  output  32  byte address for load/store (rs1 + imm).
REQ-007 Port: dmem_data_out  output  32  store data (rs2 value).
REQ-008 Port: dmem_data_in  input  32  load data, combinational from dmem_addr, same cycle.
REQ-009 Port: dmem_read_en  output  1  high only while a load executes.
REQ-010 Port: dmem_write_en  output  1  high only while a store executes; memory writes on the next rising edge.

Function
REQ-011 Single-cycle RV32I core: fetch, decode, execute, memory access and writeback all complete in one clock; CPI = 1, no pipeline and no stalls.
REQ-012 Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
REQ-013 Other opcodes (including FENCE, ECALL, EBREAK, byte/half loads and stores) execute as NOPs:
- no register write
- no memory enable
- PC+4
REQ-014 Immediates are sign-extended per the RV32I I/S/B/U/J formats; shift amount = low 5 bits; arithmetic wraps modulo 2^32.
REQ-015 Next PC:
- Default: PC+4.
- Taken branch or JAL: PC+imm.
- JALR: (rs1+imm) with bit0 cleared.
- JAL/JALR write PC+4 to rd.
REQ-016 Register file: 32x32. Two combinational read ports and one write port written on the rising edge. x0 reads 0 and writes to it are ignored.
REQ-017 LW writes dmem_data_in to rd at the clock edge ending the cycle. Addresses are word-aligned by software; low 2 address bits are driven unchanged.
REQ-018 When not a load/store, dmem_addr and dmem_data_out carry the ALU result and rs2 value (don't-care to memory); both enables are 0.
REQ-019 A store reading a register written by the previous instruction sees the updated value (no hazard, single-cycle).

Reset
REQ-020 While rst=1 at a rising edge:
- PC := RESET_PC.
- All 32 registers := 0.
REQ-021 While rst is asserted, dmem_write_en and dmem_read_en are forced to 0 and no register write occurs.
REQ-022 Reset asserted mid-program takes effect at the next rising edge. Execution restarts at RESET_PC on the first edge after rst deasserts.

Structure
REQ-023 Shared package riscv_pkg holds the opcode/funct3/funct7 constants and the ALU-operation enum.
REQ-024 The PC register lives in sub-instance pc_unit, with signal pc_current.
REQ-025 The register file lives in sub-instance regfile_unit, with array registers[0:31]; this is the one natural sub-module (regfile).
REQ-026 The fetched word is exposed as an internal signal named instruction for bench probing.
REQ-027 The bench uses combinational-read instruction and data memory models; dmem has a synchronous write gated by write_en and an asynchronous read.

Verification
REQ-028 Reset: hold rst 2 cycles, release. Required response:
- PC=0x0 and x1..x31=0.
- The first edge after release executes the instruction at 0x0.
REQ-029 ADDI and x0: program 0x00500093 (addi x1,x0,5), 0x00A00113 (addi x2,x0,10), 0x002082B3 (add x5,x1,x2). Required response:
- After 3 cycles: x1=5, x2=10, x5=15, PC=0xC.
- A following addi x0,x0,7 leaves x0=0.
REQ-030 Store/load: x2=0x100, x1=0x12345678, then sw x1,0(x2), then lw x10,0(x2). Required response:
- sw cycle: dmem_write_en=1, dmem_addr=0x100, dmem_data_out=0x12345678.
- Next cycle: x10=0x12345678 and dmem_read_en=1 during lw.
REQ-031 Branch/jump: beq x0,x0,+8 at PC=0x10 gives next PC=0x18. Then jal x1,-8 at 0x18 gives PC=0x10 and x1=0x1C.
REQ-032 Edge arithmetic:
- addi x5,x0,-1 gives x5=0xFFFFFFFF.
- srai x5,x5,4 leaves 0xFFFFFFFF.
- sltu x6,x0,x5 gives 1; slt x6,x5,x0 gives 1.
- add x5,x5,x5 wraps to 0xFFFFFFFE.
REQ-033 Reset mid-run: assert rst for 1 cycle while a store executes. Required response:
- The store is suppressed (no write_en at that edge).
- PC returns to 0 and all registers clear.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode/funct3/funct7 constants, ALU-operation enum, ALU decode and evaluate helpers
package riscv_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  localparam logic [2:0] F3_W    = 3'd2;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction
endpackage

// File: rtl/riscv_pc.sv
// riscv_pc: program counter register (clk, rst, next_pc in, pc_current out), loads RESET_PC on reset
module riscv_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  output logic [31:0] pc_current
);
  always_ff @(posedge clk) pc_current <= rst ? RESET_PC : next_pc;
endmodule

// File: rtl/riscv_regfile.sv
// riscv_regfile: 32x32 register file (clk, rst, we, rd_addr/rd_data write port, rs1/rs2 combinational reads), x0 hardwired to zero
module riscv_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);
  logic [31:0] registers [0:31];
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    else if (we && rd_addr != 5'd0)
      registers[rd_addr] <= rd_data;
  assign rs1_data = rs1_addr == 5'd0 ? '0 : registers[rs1_addr];
  assign rs2_data = rs2_addr == 5'd0 ? '0 : registers[rs2_addr];
endmodule

// File: rtl/riscv_cpu_top.sv
// riscv_cpu_top: single-cycle RV32I core (clk, rst, imem_addr/imem_data_in fetch, dmem_addr/dmem_data_out/dmem_data_in/dmem_read_en/dmem_write_en data port)
module riscv_cpu_top
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data_in,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_data_out,
  input  logic [31:0] dmem_data_in,
  output logic        dmem_read_en,
  output logic        dmem_write_en
);
  logic [31:0] instruction, pc, pc4, next_pc, rs1_data, rs2_data, alu_a, alu_b, alu_y, wd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        reg_we, wb_mem, wb_pc4, is_load, is_store, taken;
  alu_op_t     alu_op;
  assign instruction = imem_data_in;
  assign imem_addr = pc;
  assign pc4 = pc + 32'd4;
  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'd0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};
  riscv_pc #(.RESET_PC(RESET_PC)) pc_unit (
    .clk(clk), .rst(rst), .next_pc(next_pc), .pc_current(pc)
  );
  riscv_regfile regfile_unit (
    .clk(clk), .rst(rst), .we(reg_we && !rst),
    .rs1_addr(instruction[19:15]), .rs2_addr(instruction[24:20]), .rd_addr(instruction[11:7]),
    .rd_data(wd), .rs1_data(rs1_data), .rs2_data(rs2_data)
  );
  always_comb
    taken = funct3 == F3_BEQ  ? rs1_data == rs2_data :
            funct3 == F3_BNE  ? rs1_data != rs2_data :
            funct3 == F3_BLT  ? $signed(rs1_data) < $signed(rs2_data) :
            funct3 == F3_BGE  ? $signed(rs1_data) >= $signed(rs2_data) :
            funct3 == F3_BLTU ? rs1_data < rs2_data :
            funct3 == F3_BGEU ? rs1_data >= rs2_data : 1'b0;
  always_comb begin
    alu_op = ALU_ADD;
    alu_a = rs1_data;
    alu_b = imm_i;
    reg_we = 1'b0;
    wb_mem = 1'b0;
    wb_pc4 = 1'b0;
    is_load = 1'b0;
    is_store = 1'b0;
    next_pc = pc4;
    case (opcode)
      OP_LUI:    begin alu_a = '0; alu_b = imm_u; reg_we = 1'b1; end
      OP_AUIPC:  begin alu_a = pc; alu_b = imm_u; reg_we = 1'b1; end
      OP_JAL:    begin reg_we = 1'b1; wb_pc4 = 1'b1; next_pc = pc + imm_j; end
      OP_JALR:   begin reg_we = 1'b1; wb_pc4 = 1'b1; next_pc = (rs1_data + imm_i) & ~32'd1; end
      OP_BRANCH: next_pc = taken ? pc + imm_b : pc4;
      OP_LOAD:   begin is_load = funct3 == F3_W; reg_we = funct3 == F3_W; wb_mem = 1'b1; end
      OP_STORE:  begin alu_b = imm_s; is_store = funct3 == F3_W; end
      OP_IMM:    begin alu_op = alu_decode(funct3, funct3 == F3_SR && funct7 == F7_ALT); reg_we = 1'b1; end
      OP_REG:    begin alu_b = rs2_data; alu_op = alu_decode(funct3, funct7 == F7_ALT); reg_we = 1'b1; end
      default:   ;
    endcase
  end
  assign alu_y = alu(alu_op, alu_a, alu_b);
  assign wd = wb_pc4 ? pc4 : wb_mem ? dmem_data_in : alu_y;
  assign dmem_addr = alu_y;
  assign dmem_data_out = rs2_data;
  assign dmem_read_en = is_load && !rst;
  assign dmem_write_en = is_store && !rst;
endmodule

// File: tb/tb_riscv_cpu_top.sv
// tb_riscv_cpu_top: directed self-checking bench with combinational imem/dmem models
module tb_riscv_cpu_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dmem_clr = 1'b0;
  logic [31:0] imem_addr, imem_data_in, dmem_addr, dmem_data_out, dmem_data_in;
  logic dmem_read_en, dmem_write_en;
  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  int vectors = 0;
  int miscompares = 0;
  riscv_cpu_top #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data_in(imem_data_in),
    .dmem_addr(dmem_addr), .dmem_data_out(dmem_data_out), .dmem_data_in(dmem_data_in),
    .dmem_read_en(dmem_read_en), .dmem_write_en(dmem_write_en)
  );
  always #5 clk = ~clk;
  assign imem_data_in = imem[imem_addr[9:2]];
  assign dmem_data_in = dmem[dmem_addr[9:2]];
  always @(posedge clk)
    if (dmem_clr)
      for (int i = 0; i < 256; i++) dmem[i] <= '0;
    else if (dmem_write_en)
      dmem[dmem_addr[9:2]] <= dmem_data_out;
  function automatic logic [31:0] xr(input int i);
    return dut.regfile_unit.registers[i];
  endfunction
  task automatic clear_imem;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    dmem_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dmem_clr = 1'b0;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic load_store_prog;
    clear_imem();
    imem[0] = 32'h1000_0113;
    imem[1] = 32'h1234_50B7;
    imem[2] = 32'h6780_8093;
    imem[3] = 32'h0011_2023;
    imem[4] = 32'h0001_2503;
  endtask
  task automatic test_reset;
    clear_imem();
    imem[0] = 32'h0050_0093;
    do_reset();
    vectors++;
    if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 00000000", imem_addr); end
    vectors++;
    if (dut.pc_unit.pc_current !== 32'h0) begin miscompares++; $display("FAIL reset_pc_current: got %h want 00000000", dut.pc_unit.pc_current); end
    for (int i = 1; i < 32; i++) begin
      vectors++;
      if (xr(i) !== 32'h0) begin miscompares++; $display("FAIL reset_x%0d: got %h want 00000000", i, xr(i)); end
    end
    step(1);
    vectors++;
    if (xr(1) !== 32'd5) begin miscompares++; $display("FAIL reset_first_x1: got %h want 00000005", xr(1)); end
    vectors++;
    if (imem_addr !== 32'h4) begin miscompares++; $display("FAIL reset_first_pc: got %h want 00000004", imem_addr); end
  endtask
  task automatic test_addi_x0;
    clear_imem();
    imem[0] = 32'h0050_0093;
    imem[1] = 32'h00A0_0113;
    imem[2] = 32'h0020_82B3;
    imem[3] = 32'h0070_0013;
    do_reset();
    step(3);
    vectors++;
    if (xr(1) !== 32'd5) begin miscompares++; $display("FAIL addi_x1: got %h want 00000005", xr(1)); end
    vectors++;
    if (xr(2) !== 32'd10) begin miscompares++; $display("FAIL addi_x2: got %h want 0000000a", xr(2)); end
    vectors++;
    if (xr(5) !== 32'd15) begin miscompares++; $display("FAIL add_x5: got %h want 0000000f", xr(5)); end
    vectors++;
    if (imem_addr !== 32'hC) begin miscompares++; $display("FAIL addi_pc: got %h want 0000000c", imem_addr); end
    step(1);
    vectors++;
    if (xr(0) !== 32'h0) begin miscompares++; $display("FAIL x0_write: got %h want 00000000", xr(0)); end
    vectors++;
    if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL x0_pc: got %h want 00000010", imem_addr); end
  endtask
  task automatic test_store_load;
    load_store_prog();
    do_reset();
    step(3);
    vectors++;
    if (xr(2) !== 32'h100) begin miscompares++; $display("FAIL sl_x2: got %h want 00000100", xr(2)); end
    vectors++;
    if (xr(1) !== 32'h1234_5678) begin miscompares++; $display("FAIL sl_x1: got %h want 12345678", xr(1)); end
    vectors++;
    if (dmem_write_en !== 1'b1) begin miscompares++; $display("FAIL sw_write_en: got %b want 1", dmem_write_en); end
    vectors++;
    if (dmem_read_en !== 1'b0) begin miscompares++; $display("FAIL sw_read_en: got %b want 0", dmem_read_en); end
    vectors++;
    if (dmem_addr !== 32'h100) begin miscompares++; $display("FAIL sw_addr: got %h want 00000100", dmem_addr); end
    vectors++;
    if (dmem_data_out !== 32'h1234_5678) begin miscompares++; $display("FAIL sw_data: got %h want 12345678", dmem_data_out); end
    step(1);
    vectors++;
    if (dmem[64] !== 32'h1234_5678) begin miscompares++; $display("FAIL sw_mem: got %h want 12345678", dmem[64]); end
    vectors++;
    if (dmem_read_en !== 1'b1) begin miscompares++; $display("FAIL lw_read_en: got %b want 1", dmem_read_en); end
    vectors++;
    if (dmem_write_en !== 1'b0) begin miscompares++; $display("FAIL lw_write_en: got %b want 0", dmem_write_en); end
    vectors++;
    if (dmem_addr !== 32'h100) begin miscompares++; $display("FAIL lw_addr: got %h want 00000100", dmem_addr); end
    step(1);
    vectors++;
    if (xr(10) !== 32'h1234_5678) begin miscompares++; $display("FAIL lw_x10: got %h want 12345678", xr(10)); end
    vectors++;
    if (dmem_read_en !== 1'b0) begin miscompares++; $display("FAIL nop_read_en: got %b want 0", dmem_read_en); end
  endtask
  task automatic test_branch_jump;
    clear_imem();
    imem[0] = 32'h0000_1463;
    imem[4] = 32'h0000_0463;
    imem[6] = 32'hFF9F_F0EF;
    do_reset();
    step(1);
    vectors++;
    if (imem_addr !== 32'h4) begin miscompares++; $display("FAIL bne_not_taken: got %h want 00000004", imem_addr); end
    step(3);
    vectors++;
    if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL reach_beq: got %h want 00000010", imem_addr); end
    step(1);
    vectors++;
    if (imem_addr !== 32'h18) begin miscompares++; $display("FAIL beq_taken: got %h want 00000018", imem_addr); end
    step(1);
    vectors++;
    if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL jal_pc: got %h want 00000010", imem_addr); end
    vectors++;
    if (xr(1) !== 32'h1C) begin miscompares++; $display("FAIL jal_link: got %h want 0000001c", xr(1)); end
  endtask
  task automatic test_edge_arith;
    clear_imem();
    imem[0] = 32'hFFF0_0293;
    imem[1] = 32'h4042_D293;
    imem[2] = 32'h0050_3333;
    imem[3] = 32'h0002_A3B3;
    imem[4] = 32'h0052_82B3;
    imem[5] = 32'h0000_04E7;
    do_reset();
    step(1);
    vectors++;
    if (xr(5) !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL addi_neg: got %h want ffffffff", xr(5)); end
    step(1);
    vectors++;
    if (xr(5) !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL srai: got %h want ffffffff", xr(5)); end
    step(1);
    vectors++;
    if (xr(6) !== 32'd1) begin miscompares++; $display("FAIL sltu: got %h want 00000001", xr(6)); end
    step(1);
    vectors++;
    if (xr(7) !== 32'd1) begin miscompares++; $display("FAIL slt: got %h want 00000001", xr(7)); end
    step(1);
    vectors++;
    if (xr(5) !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL add_wrap: got %h want fffffffe", xr(5)); end
    step(1);
    vectors++;
    if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL jalr_pc: got %h want 00000000", imem_addr); end
    vectors++;
    if (xr(9) !== 32'h18) begin miscompares++; $display("FAIL jalr_link: got %h want 00000018", xr(9)); end
  endtask
  task automatic test_mid_reset;
    load_store_prog();
    do_reset();
    step(3);
    vectors++;
    if (dmem_write_en !== 1'b1) begin miscompares++; $display("FAIL mid_pre_store: got %b want 1", dmem_write_en); end
    rst = 1'b1;
    #1;
    vectors++;
    if (dmem_write_en !== 1'b0) begin miscompares++; $display("FAIL mid_write_en: got %b want 0", dmem_write_en); end
    step(1);
    vectors++;
    if (dmem[64] !== 32'h0) begin miscompares++; $display("FAIL mid_mem: got %h want 00000000", dmem[64]); end
    vectors++;
    if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_pc: got %h want 00000000", imem_addr); end
    vectors++;
    if (xr(1) !== 32'h0) begin miscompares++; $display("FAIL mid_x1: got %h want 00000000", xr(1)); end
    vectors++;
    if (xr(2) !== 32'h0) begin miscompares++; $display("FAIL mid_x2: got %h want 00000000", xr(2)); end
    rst = 1'b0;
    step(1);
    vectors++;
    if (xr(2) !== 32'h100) begin miscompares++; $display("FAIL mid_restart_x2: got %h want 00000100", xr(2)); end
    vectors++;
    if (imem_addr !== 32'h4) begin miscompares++; $display("FAIL mid_restart_pc: got %h want 00000004", imem_addr); end
  endtask
  initial begin
    test_reset();
    test_addi_x0();
    test_store_load();
    test_branch_jump();
    test_edge_arith();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
